// File: rtl/sub8_approx_pipe.sv
// Two-stage pipelined 8-bit approximate subtractor (A - B) with valid/ready handshake.
// Optional error statistics (err_cnt, err_wce, stat_clr) under `define SUB8_APPROX_ERRSTAT_EN.
module sub8_approx_pipe #(
   parameter int unsigned APPROX_LSB = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_a,
   input  logic [7:0] in_b,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [8:0] out_d
`ifdef SUB8_APPROX_ERRSTAT_EN
   ,
   input  logic        stat_clr,
   output logic [15:0] err_cnt,
   output logic [9:0]  err_wce
`endif
);

   localparam logic [8:0] LoMask9  = (9'h1 << APPROX_LSB) - 9'h1;
   localparam logic [7:0] LoMask   = LoMask9[7:0];
   localparam logic [7:0] HiMask   = ~LoMask;
   // Selects bit K-1 of the operands; empty when K=0 so no borrow is generated.
   localparam logic [7:0] BkSel    = LoMask ^ (LoMask >> 1);
   localparam logic [8:0] BkWeight = 9'h1 << APPROX_LSB;

   logic       ready_q;
   logic       s1_valid_q, s1_valid_d;
   logic [7:0] lo_q, a_hi_q, b_hi_q;
   logic       bk_q;
   logic       out_valid_q, out_valid_d;
   logic [8:0] out_d_q;
   logic [8:0] hi_diff;
   logic       s1_advance, in_fire, s2_load;

   assign s1_advance = ~out_valid_q | out_ready;
   assign in_ready   = ready_q & ~flush & (~s1_valid_q | s1_advance);
   assign in_fire    = in_valid & in_ready;
   assign s2_load    = s1_valid_q & s1_advance & ~flush;

   // Operand low fields are zero, so bits below K of the difference are zero as well.
   assign hi_diff = {1'b0, a_hi_q} - {1'b0, b_hi_q} - (bk_q ? BkWeight : 9'h000);

   always_comb begin
      s1_valid_d  = s1_valid_q;
      out_valid_d = out_valid_q;
      if (flush) begin
         s1_valid_d  = 1'b0;
         out_valid_d = 1'b0;
      end else begin
         if (in_fire) begin
            s1_valid_d = 1'b1;
         end else if (s1_advance) begin
            s1_valid_d = 1'b0;
         end
         if (s2_load) begin
            out_valid_d = 1'b1;
         end else if (out_ready) begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q     <= 1'b0;
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         ready_q     <= 1'b1;
         s1_valid_q  <= s1_valid_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lo_q   <= '0;
         bk_q   <= 1'b0;
         a_hi_q <= '0;
         b_hi_q <= '0;
      end else if (in_fire) begin
         lo_q   <= (in_a ^ in_b) & LoMask;
         bk_q   <= |(~in_a & in_b & BkSel);
         a_hi_q <= in_a & HiMask;
         b_hi_q <= in_b & HiMask;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_d_q <= '0;
      end else if (s2_load) begin
         out_d_q <= hi_diff | {1'b0, lo_q};
      end
   end

   assign out_valid = out_valid_q;
   assign out_d     = out_d_q;

`ifdef SUB8_APPROX_ERRSTAT_EN
   logic [8:0]  exact_s1_q, exact_s2_q;
   logic [15:0] err_cnt_q, err_cnt_d;
   logic [9:0]  err_wce_q, err_wce_d;
   logic [9:0]  err_delta, err_abs;
   logic        out_fire;

   assign out_fire  = out_valid_q & out_ready;
   // Sign-extend both 9-bit results so the 10-bit difference cannot overflow.
   assign err_delta = {out_d_q[8], out_d_q} - {exact_s2_q[8], exact_s2_q};
   assign err_abs   = err_delta[9] ? (10'd0 - err_delta) : err_delta;

   always_comb begin
      err_cnt_d = err_cnt_q;
      err_wce_d = err_wce_q;
      if (stat_clr) begin
         err_cnt_d = '0;
         err_wce_d = '0;
      end else if (out_fire) begin
         if (out_d_q != exact_s2_q && err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
         end
         if (err_abs > err_wce_q) begin
            err_wce_d = err_abs;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exact_s1_q <= '0;
         exact_s2_q <= '0;
         err_cnt_q  <= '0;
         err_wce_q  <= '0;
      end else begin
         if (in_fire) begin
            exact_s1_q <= {1'b0, in_a} - {1'b0, in_b};
         end
         if (s2_load) begin
            exact_s2_q <= exact_s1_q;
         end
         err_cnt_q <= err_cnt_d;
         err_wce_q <= err_wce_d;
      end
   end

   assign err_cnt = err_cnt_q;
   assign err_wce = err_wce_q;
`endif

endmodule

// File: tb/tb_sub8_approx_pipe.sv
// Self-checking bench for sub8_approx_pipe: directed vectors, stall/flush/reset sequences,
// and randomized traffic scored against an arithmetic reference model.
module tb_sub8_approx_pipe;

   localparam int unsigned K = 4;

   logic       clk = 1'b0;
   logic       rst_n, flush, in_valid, out_ready;
   logic [7:0] in_a, in_b;
   logic       in_ready, out_valid, in_ready0, out_valid0;
   logic [8:0] out_d, out_d0;
`ifdef SUB8_APPROX_ERRSTAT_EN
   logic        stat_clr;
   logic [15:0] err_cnt, err_cnt0;
   logic [9:0]  err_wce, err_wce0;
`endif

   always #5 clk = ~clk;

   sub8_approx_pipe #(.APPROX_LSB(K)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_d     (out_d)
`ifdef SUB8_APPROX_ERRSTAT_EN
      ,
      .stat_clr  (stat_clr),
      .err_cnt   (err_cnt),
      .err_wce   (err_wce)
`endif
   );

   sub8_approx_pipe #(.APPROX_LSB(0)) u_exact (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready0),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid0),
      .out_ready (out_ready),
      .out_d     (out_d0)
`ifdef SUB8_APPROX_ERRSTAT_EN
      ,
      .stat_clr  (stat_clr),
      .err_cnt   (err_cnt0),
      .err_wce   (err_wce0)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: XOR low field, borrow from bit K-1, exact subtract of the upper field.
   function automatic int model(input int a, input int b, input int k);
      int mask, lo, bk, hi;
      mask = (1 << k) - 1;
      lo   = (a ^ b) & mask;
      bk   = 0;
      if (k > 0) bk = (((a >> (k - 1)) & 1) == 0 && ((b >> (k - 1)) & 1) == 1) ? 1 : 0;
      hi   = (a >> k) - (b >> k) - bk;
      return ((hi * (1 << k)) | lo) & 511;
   endfunction

   function automatic int as_signed9(input int x);
      return (x > 255) ? x - 512 : x;
   endfunction

   typedef struct {
      int e4;
      int e0;
      int ex;
   } exp_t;
   exp_t sbq[$];

   logic       stall_prev = 1'b0;
   logic [8:0] stall_d    = '0;
   int         exp_cnt    = 0;
   int         exp_wce    = 0;

   always @(negedge clk) begin
      exp_t e;
      int   d;
      if (!rst_n) begin
         sbq.delete();
         stall_prev = 1'b0;
         exp_cnt    = 0;
         exp_wce    = 0;
      end else begin
`ifdef SUB8_APPROX_ERRSTAT_EN
         check("err_cnt", int'(err_cnt), exp_cnt);
         check("err_wce", int'(err_wce), exp_wce);
`endif
         if (stall_prev) begin
            check("stall_valid_held", int'(out_valid), 1);
            check("stall_data_held", int'(out_d), int'(stall_d));
         end
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               check("output_with_nothing_in_flight", int'(out_valid), 0);
            end else begin
               e = sbq.pop_front();
               check("sb_out_d", int'(out_d), e.e4);
               check("sb_out_d_k0", int'(out_d0), e.e0);
               check("sb_valid_k0", int'(out_valid0), 1);
               if (as_signed9(e.e4) != as_signed9(e.ex)) begin
                  exp_cnt = (exp_cnt < 65535) ? exp_cnt + 1 : exp_cnt;
               end
               d = as_signed9(e.e4) - as_signed9(e.ex);
               if (d < 0) d = -d;
               if (d > exp_wce) exp_wce = d;
            end
         end
         if (in_valid && in_ready) begin
            e.e4 = model(int'(in_a), int'(in_b), K);
            e.e0 = model(int'(in_a), int'(in_b), 0);
            e.ex = (int'(in_a) - int'(in_b)) & 511;
            sbq.push_back(e);
         end
         if (flush) sbq.delete();
         stall_prev = out_valid && !out_ready && !flush;
         stall_d    = out_d;
      end
   end

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      int         e4;
      int         e0;
   } vec_t;

   task automatic single_op(input vec_t v);
      in_a      = v.a;
      in_b      = v.b;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      check("op_in_ready", int'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("lat_cycle1_valid", int'(out_valid), 0);
      @(posedge clk); #1;
      check("lat_cycle2_valid", int'(out_valid), 1);
      check("op_out_d", int'(out_d), v.e4);
      check("op_out_d_k0", int'(out_d0), v.e0);
      @(posedge clk); #1;
      check("op_drained", int'(out_valid), 0);
   endtask

   // Offers new operands for 3 cycles with out_ready low; leaves in_valid high.
   task automatic fill_stalled(output int acc);
      logic took;
      acc       = 0;
      out_ready = 1'b0;
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      in_valid  = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         took = in_ready;
         if (took) acc++;
         @(posedge clk); #1;
         if (took) begin
            in_a = 8'($urandom);
            in_b = 8'($urandom);
         end
      end
   endtask

   vec_t vecs[7];

   initial begin
      int         acc;
      logic [8:0] held;
      logic       took;

      vecs[0] = '{a: 8'h10, b: 8'h20, e4: 'h1F0, e0: 'h1F0};
      vecs[1] = '{a: 8'h20, b: 8'h08, e4: 'h018, e0: 'h018};
      vecs[2] = '{a: 8'h35, b: 8'h12, e4: 'h027, e0: 'h023};
      vecs[3] = '{a: 8'h00, b: 8'h01, e4: 'h001, e0: 'h1FF};
      vecs[4] = '{a: 8'hFF, b: 8'hFF, e4: 'h000, e0: 'h000};
      vecs[5] = '{a: 8'h0F, b: 8'hF0, e4: 'h11F, e0: 'h11F};
      vecs[6] = '{a: 8'h08, b: 8'h07, e4: 'h00F, e0: 'h001};

      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_a      = '0;
      in_b      = '0;
`ifdef SUB8_APPROX_ERRSTAT_EN
      stat_clr  = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", int'(in_ready), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_d", int'(out_d), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_in_ready", int'(in_ready), 1);

      foreach (vecs[i]) single_op(vecs[i]);

      // Back-to-back stream: one result per cycle once the pipe is primed.
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_a     = 8'($urandom);
         in_b     = 8'($urandom);
         in_valid = 1'b1;
         check("stream_in_ready", int'(in_ready), 1);
         @(posedge clk); #1;
         if (i >= 1) check("stream_out_valid", int'(out_valid), 1);
      end
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      fill_stalled(acc);
      check("stall_accepts", acc, 2);
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_out_valid", int'(out_valid), 1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("release_no_loss", sbq.size(), 0);

      fill_stalled(acc);
      check("flush_setup_accepts", acc, 2);
      flush = 1'b1;
      @(negedge clk);
      check("flush_in_ready", int'(in_ready), 0);
      held = out_d;
      @(posedge clk); #1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("flush_out_valid", int'(out_valid), 0);
      check("flush_out_d_held", int'(out_d), int'(held));
      @(posedge clk); #1;
      check("flush_nothing_accepted", int'(out_valid), 0);
      single_op(vecs[2]);

      // Reset with two operations in flight.
      out_ready = 1'b1;
      in_a = 8'h55; in_b = 8'h22; in_valid = 1'b1;
      @(posedge clk); #1;
      in_a = 8'h81; in_b = 8'h7F;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_in_ready", int'(in_ready), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         check("midrst_no_stale", int'(out_valid), 0);
      end
`ifdef SUB8_APPROX_ERRSTAT_EN
      check("midrst_err_cnt", int'(err_cnt), 0);
      check("midrst_err_wce", int'(err_wce), 0);
`endif

      // Randomized traffic with backpressure and occasional flushes.
      in_valid = 1'b0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         took = in_valid && in_ready;
         @(posedge clk); #1;
         if (took || !in_valid) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_a     = 8'($urandom);
            in_b     = 8'($urandom);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 39) == 0);
      end
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 20 && sbq.size() != 0; c++) @(posedge clk);
      #1;
      check("final_drain", sbq.size(), 0);
      @(posedge clk); #1;
      check("final_out_valid", int'(out_valid), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
